// File: rtl/mem_uart_streamer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_uart_streamer_if                                            |
// | Brief    : Burst control, memory read bus and UART byte bus of the streamer |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface mem_uart_streamer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int c_CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic                         start;
    logic [c_CH_W-1:0]            ch_sel;
    logic [c_ADDR_WIDTH-1:0]      base_addr;
    logic [c_ADDR_WIDTH:0]        burst_len;
    logic                         busy;
    logic                         done;
    logic [NUM_CH-1:0]            mem_rd_en;
    logic [c_ADDR_WIDTH-1:0]      mem_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] mem_data_in;
    logic [NUM_CH-1:0]            mem_valid_in;
    logic [7:0]                   tx_data;
    logic                         tx_data_valid;
    logic                         tx_busy;
    logic [c_LVL_W-1:0]           fifo_level;

    modport master (
        input  start, ch_sel, base_addr, burst_len, mem_data_in, mem_valid_in, tx_busy,
        output busy, done, mem_rd_en, mem_addr, tx_data, tx_data_valid, fifo_level
    );

    modport slave (
        output start, ch_sel, base_addr, burst_len, mem_data_in, mem_valid_in, tx_busy,
        input  busy, done, mem_rd_en, mem_addr, tx_data, tx_data_valid, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/mem_uart_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_uart_streamer                                               |
// | Brief    : Credit-controlled burst reader feeding a word FIFO and an        |
// |            LSB-first byte serialiser towards UART_TX                       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_uart_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_uart_streamer_if.master bus
);
    localparam int c_BYTES      = DATA_WIDTH / 8;
    localparam int c_ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int c_CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int c_PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_IDX_W      = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;

    typedef enum logic [1:0] {M_IDLE, M_READ, M_DRAIN, M_DONE} main_state_t;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_WAIT} ser_state_t;

    main_state_t               r_main_state, w_main_next;
    ser_state_t                r_ser_state, w_ser_next;

    logic [c_CH_W-1:0]         r_ch;
    logic [c_ADDR_WIDTH-1:0]   r_addr;
    logic [c_ADDR_WIDTH:0]     r_len;
    logic [c_ADDR_WIDTH:0]     r_issued;
    logic [NUM_CH-1:0]         r_rd_en;
    logic                      r_inflight;
    logic                      r_busy;
    logic                      r_done;

    logic [DATA_WIDTH-1:0]     r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
    logic [c_LVL_W-1:0]        r_level;

    logic [DATA_WIDTH-1:0]     r_word;
    logic [c_IDX_W-1:0]        r_byte_idx;
    logic [7:0]                r_tx_data;
    logic                      r_tx_valid;

    logic                      w_accept, w_issue, w_credit_ok;
    logic                      w_push, w_pop, w_next_byte;
    logic [c_LVL_W:0]          w_pending;
    logic [DATA_WIDTH-1:0]     w_push_data, w_pop_data, w_shifted;

    function automatic logic [NUM_CH-1:0] f_onehot(input logic [c_CH_W-1:0] ch);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == c_CH_W'(c)) v[c] = 1'b1;
        end
        return v;
    endfunction

    // Conservative credit: the word being read this cycle and the one landing
    // this cycle both count against the FIFO space.
    assign w_pending   = {1'b0, r_level}
                       + {{c_LVL_W{1'b0}}, |r_rd_en}
                       + {{c_LVL_W{1'b0}}, r_inflight};
    assign w_credit_ok = w_pending < (c_LVL_W+1)'(FIFO_DEPTH);

    assign w_push      = r_inflight && bus.mem_valid_in[r_ch];
    assign w_push_data = bus.mem_data_in[r_ch*DATA_WIDTH +: DATA_WIDTH];
    assign w_pop_data  = r_fifo[r_rd_ptr];
    assign w_shifted   = r_word >> 8;

    always_comb begin
        w_main_next = r_main_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        case (r_main_state)
            M_IDLE: begin
                if (bus.start && (bus.burst_len != '0)) begin
                    w_accept    = 1'b1;
                    w_main_next = M_READ;
                end
            end
            M_READ: begin
                if (r_issued == r_len) w_main_next = M_DRAIN;
                else if (w_credit_ok)  w_issue     = 1'b1;
            end
            M_DRAIN: begin
                if (!r_inflight && (r_rd_en == '0) && (r_level == '0) &&
                    (r_ser_state == S_IDLE) && !bus.tx_busy)
                    w_main_next = M_DONE;
            end
            M_DONE:  w_main_next = M_IDLE;
            default: w_main_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_state <= M_IDLE;
            r_ch         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_issued     <= '0;
            r_rd_en      <= '0;
            r_inflight   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_main_state <= w_main_next;
            r_inflight   <= |r_rd_en;
            r_done       <= (w_main_next == M_DONE);
            if (w_accept) begin
                r_ch     <= bus.ch_sel;
                r_addr   <= bus.base_addr;
                r_len    <= bus.burst_len;
                r_issued <= (c_ADDR_WIDTH+1)'(1);
                r_rd_en  <= f_onehot(bus.ch_sel);
                r_busy   <= 1'b1;
            end else if (w_issue) begin
                r_addr   <= (r_addr == c_ADDR_WIDTH'(MEM_DEPTH-1)) ? '0 : r_addr + 1'b1;
                r_issued <= r_issued + 1'b1;
                r_rd_en  <= f_onehot(r_ch);
            end else begin
                r_rd_en  <= '0;
            end
            if (r_main_state == M_DONE) r_busy <= 1'b0;
        end
    end

    always_comb begin
        w_ser_next  = r_ser_state;
        w_pop       = 1'b0;
        w_next_byte = 1'b0;
        case (r_ser_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop      = 1'b1;
                    w_ser_next = S_SEND;
                end
            end
            S_SEND: w_ser_next = S_GAP;
            // UART_TX raises busy a cycle late, so it is not trusted here.
            S_GAP:  w_ser_next = S_WAIT;
            S_WAIT: begin
                if (!bus.tx_busy) begin
                    if (r_byte_idx == c_IDX_W'(c_BYTES-1)) begin
                        w_ser_next = S_IDLE;
                    end else begin
                        w_next_byte = 1'b1;
                        w_ser_next  = S_SEND;
                    end
                end
            end
            default: w_ser_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ser_state <= S_IDLE;
            r_word      <= '0;
            r_byte_idx  <= '0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
        end else begin
            r_ser_state <= w_ser_next;
            r_tx_valid  <= w_pop || w_next_byte;
            if (w_pop) begin
                r_word     <= w_pop_data;
                r_byte_idx <= '0;
                r_tx_data  <= w_pop_data[7:0];
            end else if (w_next_byte) begin
                r_word     <= w_shifted;
                r_byte_idx <= r_byte_idx + 1'b1;
                r_tx_data  <= w_shifted[7:0];
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_push_data;
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.mem_rd_en     = r_rd_en;
    assign bus.mem_addr      = r_addr;
    assign bus.tx_data       = r_tx_data;
    assign bus.tx_data_valid = r_tx_valid;
    assign bus.fifo_level    = r_level;
endmodule
`default_nettype wire

// File: tb/tb_mem_uart_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_uart_streamer                                            |
// | Brief    : Scoreboard bench with memory and UART_TX models                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mem_uart_streamer;
    localparam int c_DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_uart_streamer_if #(.DATA_WIDTH(32), .MEM_DEPTH(64), .NUM_CH(2), .FIFO_DEPTH(4)) bus ();

    mem_uart_streamer #(.DATA_WIDTH(32), .MEM_DEPTH(64), .NUM_CH(2), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [2][c_DEPTH];
    logic [7:0]  exp_q[$];
    int          addr_q[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          rd_count = 0;
    int          cyc = 0;
    int          last_pulse = -1;
    int          busy_cnt = 0;
    bit          in_reset = 1'b1;
    bit          force_busy = 1'b0;
    bit          spurious = 1'b0;
    logic [1:0]  pend_v = '0;
    logic [5:0]  pend_a = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc++;

    // Memory channels: data and valid one cycle after the read enable.
    always @(negedge clk) begin
        logic [1:0]  v;
        logic [63:0] d;
        v = pend_v;
        d = '0;
        for (int c = 0; c < 2; c++) if (pend_v[c]) d[c*32 +: 32] = mem[c][pend_a];
        if (spurious) begin
            v[0]     = 1'b1;
            d[31:0]  = 32'hDEADBEEF;
        end
        bus.mem_valid_in = v;
        bus.mem_data_in  = d;
        pend_v = bus.mem_rd_en;
        pend_a = bus.mem_addr;
    end

    // UART_TX: busy for a random stretch after each byte, or forced high.
    always @(negedge clk) begin
        if (bus.tx_data_valid) busy_cnt = $urandom_range(0, 4);
        else if (busy_cnt > 0) busy_cnt--;
        bus.tx_busy = force_busy || (busy_cnt > 0);
    end

    // Monitor: bytes, read addresses, done pulses and FIFO bound.
    always @(negedge clk) begin
        if (!in_reset) begin
            if (bus.tx_data_valid) begin
                if (exp_q.size() == 0) chk("unexpected_byte", {56'h0, bus.tx_data}, 64'h1_0000);
                else chk("tx_byte", bus.tx_data, exp_q.pop_front());
                if (last_pulse >= 0) chk("byte_spacing_ge3", 64'((cyc - last_pulse) >= 3), 1);
                last_pulse = cyc;
            end
            if (bus.mem_rd_en != '0) begin
                rd_count++;
                if (addr_q.size() == 0) chk("unexpected_read", bus.mem_rd_en, 0);
                else begin
                    int e;
                    e = addr_q.pop_front();
                    chk("rd_addr", bus.mem_addr, e % c_DEPTH);
                    chk("rd_en_onehot", bus.mem_rd_en, 64'(1) << (e / c_DEPTH));
                end
            end
            if (bus.done) done_cnt++;
            chk("fifo_level_le4", 64'(bus.fifo_level <= 4), 1);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected traffic is derived from the memory image, then start is pulsed.
    task automatic start_burst(input int ch, input int base, input int len);
        for (int i = 0; i < len; i++) begin
            int a;
            logic [31:0] w;
            a = (base + i) % c_DEPTH;
            addr_q.push_back(ch * c_DEPTH + a);
            w = mem[ch][a];
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        end
        bus.ch_sel    = 1'(ch);
        bus.base_addr = 6'(base);
        bus.burst_len = 7'(len);
        bus.start     = 1'b1;
        tick(1);
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n0;
        int k;
        n0 = done_cnt;
        k  = 0;
        while (done_cnt == n0 && k < 5000) begin
            tick(1);
            k++;
        end
        chk({tag, "_done_once"}, done_cnt - n0, 1);
        chk({tag, "_busy_low"}, bus.busy, 0);
        chk({tag, "_bytes_left"}, exp_q.size(), 0);
        chk({tag, "_reads_left"}, addr_q.size(), 0);
        tick(3);
        chk({tag, "_no_extra_done"}, done_cnt - n0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_tx_data"}, bus.tx_data, 0);
        chk({tag, "_tx_valid"}, bus.tx_data_valid, 0);
        chk({tag, "_level"}, bus.fifo_level, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0, k;
        bus.start = 1'b0;
        bus.ch_sel = '0;
        bus.base_addr = '0;
        bus.burst_len = '0;
        bus.tx_busy = 1'b0;
        bus.mem_valid_in = '0;
        bus.mem_data_in = '0;
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < c_DEPTH; a++) mem[c][a] = $urandom;
        mem[1][5] = 32'hA1B2C3D4;

        tick(3);
        check_reset_values("reset");
        rst = 1'b0;
        in_reset = 1'b0;
        tick(2);

        // Single word with first-transaction latency checks.
        start_burst(1, 5, 1);
        chk("t1_busy", bus.busy, 1);
        chk("t1_rd_en", bus.mem_rd_en, 2'b10);
        chk("t1_addr", bus.mem_addr, 5);
        tick(2);
        chk("t3_level", bus.fifo_level, 1);
        tick(1);
        chk("t4_tx_valid", bus.tx_data_valid, 1);
        chk("t4_tx_data", bus.tx_data, 8'hD4);
        wait_done("single");

        // Address wrap-around.
        start_burst(0, 62, 4);
        wait_done("wrap");

        // Backpressure: serialiser holds one word, FIFO fills to four.
        force_busy = 1'b1;
        r0 = rd_count;
        start_burst(0, 20, 16);
        tick(200);
        chk("bp_level_full", bus.fifo_level, 4);
        chk("bp_reads_stalled", rd_count - r0, 5);
        force_busy = 1'b0;
        wait_done("backpressure");

        // Start during a burst is ignored.
        start_burst(0, 10, 8);
        tick(3);
        bus.ch_sel = 1'b1;
        bus.base_addr = 6'd40;
        bus.burst_len = 7'd3;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        wait_done("ignore_busy");

        // Zero-length start in IDLE is ignored.
        r0 = rd_count;
        d0 = done_cnt;
        bus.ch_sel = 1'b1;
        bus.base_addr = 6'd7;
        bus.burst_len = 7'd0;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(10);
        chk("zero_len_reads", rd_count - r0, 0);
        chk("zero_len_busy", bus.busy, 0);
        chk("zero_len_done", done_cnt - d0, 0);

        // Channel isolation against spurious ch0 valids.
        spurious = 1'b1;
        start_burst(1, $urandom_range(0, 63), 6);
        wait_done("isolation");
        spurious = 1'b0;

        // Reset after the third read of a 10-word burst.
        r0 = rd_count;
        start_burst(0, 30, 10);
        k = 0;
        while (rd_count - r0 < 3 && k < 1000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("rst_third_read_seen", 64'(rd_count - r0 >= 3), 1);
        tick(1);
        in_reset = 1'b1;
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        d0 = done_cnt;
        tick(1);
        check_reset_values("midrst");
        rst = 1'b0;
        last_pulse = -1;
        tick(1);
        in_reset = 1'b0;
        tick(20);
        chk("midrst_no_done", done_cnt - d0, 0);
        start_burst(1, 3, 3);
        wait_done("after_rst");

        // Randomised bursts.
        for (int i = 0; i < 8; i++) begin
            start_burst($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(1, 12));
            wait_done("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
